// File: rtl/wide_word_lane_unpacker_if.sv
// Bundle of the wide-word input stream, the narrow lane output stream and status signals
// for wide_word_lane_unpacker. master drives the source/sink side, slave is the unpacker.
interface wide_word_lane_unpacker_if #(
  parameter int unsigned DATA_WIDTH_BIT = 512,
  parameter int unsigned LANE_W         = 16,
  parameter int unsigned OUT_W          = 16
) ();
  localparam int unsigned NUM_LANES = DATA_WIDTH_BIT / LANE_W;
  localparam int unsigned IDX_W     = $clog2(NUM_LANES);

  logic [DATA_WIDTH_BIT-1:0] in_data;
  logic [3:0]                in_shift;
  logic                      in_valid;
  logic                      in_ready;
  logic [OUT_W-1:0]          out_data;
  logic [IDX_W-1:0]          out_idx;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;
  logic                      clr_sat;
  logic                      sat_flag;
  logic [15:0]               word_cnt;

  modport master (
    output in_data, in_shift, in_valid, out_ready, clr_sat,
    input  in_ready, out_data, out_idx, out_last, out_valid, sat_flag, word_cnt
  );

  modport slave (
    input  in_data, in_shift, in_valid, out_ready, clr_sat,
    output in_ready, out_data, out_idx, out_last, out_valid, sat_flag, word_cnt
  );
endinterface

// File: rtl/wide_word_lane_unpacker.sv
// Holds one packed word and emits its signed lanes one per beat, each rescaled by a
// rounding arithmetic right shift and saturated to OUT_W bits.
module wide_word_lane_unpacker #(
  parameter int unsigned DATA_WIDTH_BIT = 512,
  parameter int unsigned LANE_W         = 16,
  parameter int unsigned OUT_W          = 16
) (
  input logic                      clk,
  input logic                      rst,
  wide_word_lane_unpacker_if.slave bus
);
  localparam int unsigned NUM_LANES = DATA_WIDTH_BIT / LANE_W;
  localparam int unsigned IDX_W     = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_LANES - 1);
  localparam int SatMaxInt = (1 << (OUT_W - 1)) - 1;
  localparam int SatMinInt = -(1 << (OUT_W - 1));
  localparam logic signed [LANE_W:0] SatMax = (LANE_W + 1)'(SatMaxInt);
  localparam logic signed [LANE_W:0] SatMin = (LANE_W + 1)'(SatMinInt);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH_BIT-1:0] word_q, word_d;
  logic [3:0]                shift_q, shift_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      sat_q, sat_d;
  logic [15:0]               cnt_q, cnt_d;

  logic                      out_valid;
  logic                      out_last;
  logic                      beat_hs;
  logic                      last_hs;
  logic                      in_ready;
  logic                      take;

  logic signed [LANE_W-1:0]  lane;
  logic signed [LANE_W:0]    lane_ext;
  logic signed [LANE_W:0]    rnd;
  logic signed [LANE_W:0]    scaled;
  logic                      sat_hi;
  logic                      sat_lo;
  logic [OUT_W-1:0]          out_data;

  // Output datapath: depends only on held word, index and shift.
  always_comb begin
    lane     = word_q[idx_q * LANE_W +: LANE_W];
    lane_ext = {lane[LANE_W-1], lane};
    rnd      = (LANE_W + 1)'(1) << (shift_q - 4'd1);
    if (shift_q == 4'd0) begin
      scaled = lane_ext;
    end else begin
      scaled = (lane_ext + rnd) >>> shift_q;
    end
    sat_hi = scaled > SatMax;
    sat_lo = scaled < SatMin;
    if (sat_hi) begin
      out_data = SatMax[OUT_W-1:0];
    end else if (sat_lo) begin
      out_data = SatMin[OUT_W-1:0];
    end else begin
      out_data = scaled[OUT_W-1:0];
    end
  end

  always_comb begin
    out_valid = (state_q == StStream);
    out_last  = (idx_q == LastIdx);
    beat_hs   = out_valid & bus.out_ready;
    last_hs   = beat_hs & out_last;
    // Accepting on the last beat keeps back-to-back words free of bubbles.
    in_ready  = (state_q == StIdle) | last_hs;
    take      = bus.in_valid & in_ready;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    if (take) begin
      word_d  = bus.in_data;
      shift_d = bus.in_shift;
      idx_d   = '0;
      state_d = StStream;
    end else if (last_hs) begin
      idx_d   = '0;
      state_d = StIdle;
    end else if (beat_hs) begin
      idx_d = idx_q + 1'b1;
    end
    if (last_hs) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (beat_hs & (sat_hi | sat_lo)) begin
      sat_d = 1'b1;
    end else if (bus.clr_sat) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_data  = out_data;
    bus.out_idx   = idx_q;
    bus.out_last  = out_last;
    bus.sat_flag  = sat_q;
    bus.word_cnt  = cnt_q;
  end
endmodule

// File: tb/tb_wide_word_lane_unpacker.sv
// Bench for wide_word_lane_unpacker: a 16-bit and an 8-bit output instance share one
// stimulus stream and are compared against an integer scaling model.
module tb_wide_word_lane_unpacker;
  localparam int unsigned DW = 512;
  localparam int unsigned LW = 16;
  localparam int unsigned NL = DW / LW;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    in_shift = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_sat = 1'b0;
  int            errs = 0;
  int            checks = 0;
  int            exp_cnt = 0;

  always #5 clk = ~clk;

  wide_word_lane_unpacker_if #(.DATA_WIDTH_BIT(DW), .LANE_W(LW), .OUT_W(16)) b16 ();
  wide_word_lane_unpacker_if #(.DATA_WIDTH_BIT(DW), .LANE_W(LW), .OUT_W(8))  b8 ();

  assign b16.in_data   = in_data;
  assign b16.in_shift  = in_shift;
  assign b16.in_valid  = in_valid;
  assign b16.out_ready = out_ready;
  assign b16.clr_sat   = clr_sat;
  assign b8.in_data    = in_data;
  assign b8.in_shift   = in_shift;
  assign b8.in_valid   = in_valid;
  assign b8.out_ready  = out_ready;
  assign b8.clr_sat    = clr_sat;

  wide_word_lane_unpacker #(.DATA_WIDTH_BIT(DW), .LANE_W(LW), .OUT_W(16)) u16 (
    .clk(clk), .rst(rst), .bus(b16)
  );
  wide_word_lane_unpacker #(.DATA_WIDTH_BIT(DW), .LANE_W(LW), .OUT_W(8)) u8 (
    .clk(clk), .rst(rst), .bus(b8)
  );

  function automatic int ref_raw(input logic [DW-1:0] w, input int k, input int s);
    logic signed [LW-1:0] l;
    int x;
    l = w[k*LW +: LW];
    x = int'(l);
    if (s == 0) return x;
    return (x + (1 << (s - 1))) >>> s;
  endfunction

  function automatic int ref_clamp(input int y, input int ow);
    int hi, lo;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (y > hi) return hi;
    if (y < lo) return lo;
    return y;
  endfunction

  function automatic logic [15:0] exp16(input logic [DW-1:0] w, input int k, input int s);
    int c;
    c = ref_clamp(ref_raw(w, k, s), 16);
    return c[15:0];
  endfunction

  function automatic logic [7:0] exp8(input logic [DW-1:0] w, input int k, input int s);
    int c;
    c = ref_clamp(ref_raw(w, k, s), 8);
    return c[7:0];
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Tasks below start and end just after a rising edge.
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sat = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic put_word(input logic [DW-1:0] w, input logic [3:0] s, output bit ok);
    ok = 1'b0;
    in_data = w; in_shift = s; in_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = (b16.in_ready === 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
      errs++; $display("FAIL reset_hs got valid=%b ready=%b v8=%b want 0 1 0",
                       b16.out_valid, b16.in_ready, b8.out_valid);
    end
    checks++;
    if (b16.word_cnt !== 16'd0 || b16.sat_flag !== 1'b0 || b8.sat_flag !== 1'b0) begin
      errs++; $display("FAIL reset_status got cnt=%0d sat=%b sat8=%b want 0 0 0",
                       b16.word_cnt, b16.sat_flag, b8.sat_flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    logic [3:0] s;
    bit ok;
    w = rand_word();
    out_ready = 1'b1;
    put_word(w, 4'd0, ok);
    checks++; if (!ok) begin errs++; $display("FAIL rmid_accept got timeout want accept"); end
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (b16.out_idx !== IW'(10) || b16.out_valid !== 1'b1) begin
      errs++; $display("FAIL rmid_idx got idx=%0d valid=%b want 10 1", b16.out_idx, b16.out_valid);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1 || b16.word_cnt !== 16'(exp_cnt)) begin
      errs++; $display("FAIL rmid_after got valid=%b ready=%b cnt=%0d want 0 1 %0d",
                       b16.out_valid, b16.in_ready, b16.word_cnt, exp_cnt);
    end
    @(posedge clk); #1;
    w = rand_word();
    s = 4'($urandom_range(0, 15));
    out_ready = 1'b1;
    put_word(w, s, ok);
    checks++; if (!ok) begin errs++; $display("FAIL rmid_accept2 got timeout want accept"); end
    for (int k = 0; k < NL; k++) begin
      @(negedge clk);
      checks++;
      if (b16.out_valid !== 1'b1 || b16.out_idx !== IW'(k) || b16.out_data !== exp16(w, k, s)) begin
        errs++; $display("FAIL rmid_beat k=%0d got v=%b idx=%0d d=%h want 1 %0d %h",
                         k, b16.out_valid, b16.out_idx, b16.out_data, k, exp16(w, k, s));
      end
      @(posedge clk); #1;
    end
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (b16.word_cnt !== 16'(exp_cnt)) begin
      errs++; $display("FAIL rmid_cnt got %0d want %0d", b16.word_cnt, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    logic [DW-1:0] w;
    bit ok;
    do_reset();
    for (int k = 0; k < NL; k++) w[k*LW +: LW] = 16'(k * 256);
    out_ready = 1'b1;
    put_word(w, 4'd0, ok);
    checks++; if (!ok) begin errs++; $display("FAIL ramp_accept got timeout want accept"); end
    for (int k = 0; k < NL; k++) begin
      @(negedge clk);
      checks++;
      if (b16.out_valid !== 1'b1 || b16.out_idx !== IW'(k) || b16.out_data !== 16'(k * 256) ||
          b16.out_last !== (k == NL - 1)) begin
        errs++; $display("FAIL ramp_beat k=%0d got v=%b idx=%0d d=%h last=%b want d=%h",
                         k, b16.out_valid, b16.out_idx, b16.out_data, b16.out_last, 16'(k * 256));
      end
      @(posedge clk); #1;
    end
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (b16.out_valid !== 1'b0 || b16.word_cnt !== 16'd1) begin
      errs++; $display("FAIL ramp_end got valid=%b cnt=%0d want 0 1", b16.out_valid, b16.word_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    logic [DW-1:0] w;
    logic [15:0] fix [3];
    logic [15:0] e;
    bit ok;
    fix = '{16'h0002, 16'hFFFF, 16'h0080};
    w = rand_word();
    w[15:0] = 16'h0180; w[31:16] = 16'hFE80; w[47:32] = 16'h7FFF;
    out_ready = 1'b1;
    put_word(w, 4'd8, ok);
    checks++; if (!ok) begin errs++; $display("FAIL round_accept got timeout want accept"); end
    for (int k = 0; k < NL; k++) begin
      @(negedge clk);
      e = (k < 3) ? fix[k] : exp16(w, k, 8);
      checks++;
      if (b16.out_idx !== IW'(k) || b16.out_data !== e || b8.out_data !== exp8(w, k, 8)) begin
        errs++; $display("FAIL round_beat k=%0d got idx=%0d d=%h d8=%h want %h %h",
                         k, b16.out_idx, b16.out_data, b8.out_data, e, exp8(w, k, 8));
      end
      @(posedge clk); #1;
    end
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (b16.sat_flag !== 1'b0 || b16.word_cnt !== 16'(exp_cnt)) begin
      errs++; $display("FAIL round_end got sat=%b cnt=%0d want 0 %0d",
                       b16.sat_flag, b16.word_cnt, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [DW-1:0] w;
    logic [7:0] e;
    bit ok;
    w = rand_word();
    w[15:0] = 16'h0100; w[31:16] = 16'hFF00;
    clr_sat = 1'b1;
    @(posedge clk); #1 clr_sat = 1'b0;
    @(negedge clk);
    checks++; if (b8.sat_flag !== 1'b0) begin
      errs++; $display("FAIL sat_clr0 got %b want 0", b8.sat_flag);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    put_word(w, 4'd0, ok);
    checks++; if (!ok) begin errs++; $display("FAIL sat_accept got timeout want accept"); end
    for (int k = 0; k < NL; k++) begin
      @(negedge clk);
      e = (k == 0) ? 8'h7F : (k == 1) ? 8'h80 : exp8(w, k, 0);
      checks++;
      if (b8.out_idx !== IW'(k) || b8.out_data !== e) begin
        errs++; $display("FAIL sat_beat k=%0d got idx=%0d d8=%h want %h", k, b8.out_idx,
                         b8.out_data, e);
      end
      @(posedge clk); #1;
    end
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (b8.sat_flag !== 1'b1 || b16.sat_flag !== 1'b0 || b8.word_cnt !== 16'(exp_cnt)) begin
      errs++; $display("FAIL sat_set got sat8=%b sat16=%b cnt=%0d want 1 0 %0d",
                       b8.sat_flag, b16.sat_flag, b8.word_cnt, exp_cnt);
    end
    @(posedge clk); #1 clr_sat = 1'b1;
    @(posedge clk); #1 clr_sat = 1'b0;
    @(negedge clk);
    checks++; if (b8.sat_flag !== 1'b0) begin
      errs++; $display("FAIL sat_clr got %b want 0", b8.sat_flag);
    end
    // Hold clr_sat through a saturating beat: the set must win.
    @(posedge clk); #1 clr_sat = 1'b1;
    put_word(w, 4'd0, ok);
    checks++; if (!ok) begin errs++; $display("FAIL sat_accept2 got timeout want accept"); end
    @(negedge clk);
    checks++; if (b8.sat_flag !== 1'b0) begin
      errs++; $display("FAIL sat_pre got %b want 0", b8.sat_flag);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (b8.sat_flag !== 1'b1) begin
      errs++; $display("FAIL sat_priority got %b want 1", b8.sat_flag);
    end
    repeat (NL - 1) @(posedge clk);
    #1 clr_sat = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_stall();
    logic [DW-1:0] w;
    logic [3:0] s;
    logic [15:0] held;
    bit ok, was_stall;
    int k, c;
    w = rand_word();
    s = 4'($urandom_range(0, 15));
    out_ready = 1'b0;
    put_word(w, s, ok);
    checks++; if (!ok) begin errs++; $display("FAIL stall_accept got timeout want accept"); end
    k = 0; c = 0; was_stall = 1'b0; held = '0;
    while (k < NL && c < 200) begin
      out_ready = (c % 2 == 0);
      @(negedge clk);
      checks++;
      if (b16.out_valid !== 1'b1 || b16.out_idx !== IW'(k) || b16.out_data !== exp16(w, k, s) ||
          b8.out_data !== exp8(w, k, s)) begin
        errs++; $display("FAIL stall_beat k=%0d got v=%b idx=%0d d=%h d8=%h want %h %h", k,
                         b16.out_valid, b16.out_idx, b16.out_data, b8.out_data,
                         exp16(w, k, s), exp8(w, k, s));
      end
      if (was_stall) begin
        checks++;
        if (b16.out_data !== held) begin
          errs++; $display("FAIL stall_hold k=%0d got %h want %h", k, b16.out_data, held);
        end
      end
      was_stall = !out_ready;
      held = b16.out_data;
      if (out_ready) k++;
      c++;
      @(posedge clk); #1;
    end
    checks++; if (k != NL) begin errs++; $display("FAIL stall_done got %0d beats want %0d", k, NL); end
    exp_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (b16.out_valid !== 1'b0 || b16.word_cnt !== 16'(exp_cnt)) begin
      errs++; $display("FAIL stall_end got valid=%b cnt=%0d want 0 %0d",
                       b16.out_valid, b16.word_cnt, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ws [3];
    logic [3:0] ss [3];
    int wi, b, wn, ln;
    bit acc;
    for (int i = 0; i < 3; i++) begin
      ws[i] = rand_word();
      ss[i] = 4'($urandom_range(0, 15));
    end
    wi = 0; in_data = ws[0]; in_shift = ss[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c <= 3 * NL; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) begin
          errs++; $display("FAIL b2b_start got ready=%b valid=%b want 1 0",
                           b16.in_ready, b16.out_valid);
        end
        acc = 1'b1;
      end else begin
        b = c - 1; wn = b / NL; ln = b % NL;
        checks++;
        if (b16.out_valid !== 1'b1 || b16.out_idx !== IW'(ln) ||
            b16.out_data !== exp16(ws[wn], ln, ss[wn]) || b8.out_data !== exp8(ws[wn], ln, ss[wn]) ||
            b16.in_ready !== (ln == NL - 1)) begin
          errs++; $display("FAIL b2b_beat b=%0d got v=%b idx=%0d d=%h d8=%h rdy=%b want 1 %0d %h %h %b",
                           b, b16.out_valid, b16.out_idx, b16.out_data, b8.out_data, b16.in_ready,
                           ln, exp16(ws[wn], ln, ss[wn]), exp8(ws[wn], ln, ss[wn]), ln == NL - 1);
        end
        acc = (ln == NL - 1);
      end
      @(posedge clk); #1;
      if (acc) begin
        wi++;
        if (wi < 3) begin
          in_data = ws[wi]; in_shift = ss[wi];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    exp_cnt += 3;
    @(negedge clk);
    checks++;
    if (b16.out_valid !== 1'b0 || b16.word_cnt !== 16'(exp_cnt)) begin
      errs++; $display("FAIL b2b_end got valid=%b cnt=%0d want 0 %0d",
                       b16.out_valid, b16.word_cnt, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_ramp();
    test_rounding();
    test_saturation();
    test_stall();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
